// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter
//   Parametrised up/down counter with prescaler, programmable upper limit,
//   wrap / saturate / one-shot modes, terminal-count pulse and compare match.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   en        count enable (0 freezes prescaler and count)
//   load      synchronous load strobe (beats en / done / step)
//   load_val  value to load, clamped to limit
//   dir       1 = up, 0 = down
//   mode      00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   limit     upper bound of the count range 0..limit
//   presc     one step every presc+1 enabled cycles
//   cmp_val   compare value for match
//   count     current count (registered)
//   tc        terminal-count pulse, one cycle (registered)
//   match     count == cmp_val (combinational)
//   done      one-shot finished flag, sticky (registered)
// ---------------------------------------------------------------------------
module param_updown_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] presc,
  input  logic [WIDTH-1:0]   cmp_val,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               match,
  output logic               done
);

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [PRESC_W-1:0] psc;
  logic [PRESC_W-1:0] psc_nxt;
  logic [WIDTH-1:0]   count_nxt;
  logic               tc_nxt;
  logic               done_nxt;
  logic               at_bound;
  logic               step;

  // Up boundary uses >= so a limit lowered below the count still terminates.
  assign at_bound = dir ? (count >= limit) : (count == '0);
  assign step     = en && !done && (psc == presc);

  // Next-state computation: load beats step; tc defaults low every edge.
  always_comb begin
    count_nxt = count;
    psc_nxt   = psc;
    tc_nxt    = 1'b0;
    done_nxt  = done;
    if (load) begin
      count_nxt = (load_val > limit) ? limit : load_val;
      psc_nxt   = '0;
      done_nxt  = 1'b0;
    end else if (en && !done) begin
      if (!step) begin
        psc_nxt = psc + PRESC_W'(1);
      end else begin
        psc_nxt = '0;
        if (!at_bound) begin
          count_nxt = dir ? (count + WIDTH'(1)) : (count - WIDTH'(1));
        end else begin
          tc_nxt = 1'b1;
          case (mode)
            MODE_SAT:     count_nxt = dir ? limit : '0;
            MODE_ONESHOT: done_nxt  = 1'b1;
            default:      count_nxt = dir ? '0 : limit;
          endcase
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      psc   <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_nxt;
      psc   <= psc_nxt;
      tc    <= tc_nxt;
      done  <= done_nxt;
    end
  end

  assign match = (count == cmp_val);

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised up/down counter. It is the next-generation replacement for the simple 8-bit loadable up-counter in our Tiny Tapeout designs. It adds a configurable width, programmable upper limit, prescaler, direction, wrap/saturate/one-shot modes, a terminal-count pulse and a compare-match flag. It sits between the pin-level wrapper (ui_in/uio_in decode) and the output mux driving uo_out.

Parameters:
WIDTH, 8, counter and limit/compare/load width in bits (>=2)
PRESC_W, 4, prescaler divisor width in bits (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  count enable; 0 freezes prescaler and count
load  in  1  synchronous load strobe
load_val  in  WIDTH  value loaded on load
dir  in  1  1=count up, 0=count down
mode  in  2  00=wrap, 01=saturate, 10=one-shot, 11=treated as wrap
limit  in  WIDTH  upper bound; count range is 0..limit
presc  in  PRESC_W  one step every presc+1 enabled cycles
cmp_val  in  WIDTH  compare value
count  out  WIDTH  current count (registered)
tc  out  1  terminal-count pulse (registered, 1 cycle)
match  out  1  combinational: count == cmp_val
done  out  1  one-shot finished flag (registered, sticky)

Behaviour:
- Reset: rst=1 immediately clears count, the internal prescaler counter psc, tc and done. Their values are 0 while rst is held. Reset mid-operation discards any in-progress prescale.
- Priority per edge: rst > load > step.
- Load:
  - count <= load_val, clamped to limit if load_val > limit.
  - psc <= 0, done <= 0, tc <= 0.
  - Load acts regardless of en or done.
- Prescaler:
  - On an edge with en=1, no load and done=0: if psc==presc then psc <= 0 and a step occurs, else psc <= psc+1.
  - presc=0 gives one step per enabled cycle.
  - en=0 holds psc and count.
- Boundary: up means count >= limit (covers limit lowered below count at runtime); down means count == 0.
- Step not at boundary: count +/- 1 per dir.
- Step at boundary, tc <= 1 for one cycle (same edge as the count update):
  - wrap: up goes limit->0; down goes 0->limit.
  - saturate: count holds at the boundary value (limit or 0). tc pulses on every step attempted at the boundary.
  - one-shot: count holds and done <= 1. While done=1, steps and psc are frozen; only load or rst clear done.
- tc is 0 on every edge without a boundary step.
- Step latency: count changes on the edge that completes the prescale. It is visible the following cycle, together with tc.
- dir, mode, limit and presc changes take effect on the next edge. No internal capture.
- Arithmetic is modulo 2^WIDTH internally, but with the limit rules count never exceeds max(limit, last loaded clamped value).
- limit=0: every step is at the boundary. In wrap mode count stays 0 and tc pulses every step.
- match depends only on count and cmp_val. No latency or registering.

Test Plan:
- WIDTH=8, limit=9, presc=0, dir=1, mode=wrap, en=1 after rst -> count 0,1,..,9,0,1; tc high exactly on the cycle count shows 0 after 9; period 10 cycles.
- Same setup with presc=2 -> count advances every 3 cycles. Dropping en for 5 cycles mid-prescale freezes both count and psc, and counting resumes with the remaining prescale.
- limit=0x10, load=1 with load_val=0x20 -> count=0x10. Load asserted on a step cycle with en=1 and load_val=0x05 -> count=0x05 (load wins) and tc=0.
- dir=0, mode=saturate, load 2, presc=0 -> count 2,1,0,0,0; tc=1 on each step attempted at 0 (2nd and 3rd cycles after reaching 0). cmp_val=1 -> match high only while count=1.
- dir=1, mode=one-shot, limit=3, from 0 -> 0,1,2,3; next step gives tc pulse, done=1, count stays 3 indefinitely. A load of 0 clears done and restarts counting.
- Assert rst asynchronously (between edges) at count=5 with psc=1, presc=3 -> count, tc, done go to 0 without a clock edge. After release, the first increment occurs on the 4th enabled edge.
